// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and elaboration helpers for the UART receive path.
//   rx_state_e    : frame FSM states
//   clks_per_bit  : system clocks per bit period
//   half_bit      : clocks from the start edge to the middle of the start bit
//   cnt_width     : baud counter width able to hold CLKS_PER_BIT-1
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    function automatic int clks_per_bit(input int f_clk, input int baud);
        return f_clk / baud;
    endfunction

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

    function automatic int cnt_width(input int cpb);
        return $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Byte hand-off from the UART receiver to its consumer.
//   rx_data    : received byte, bit 0 = first bit on the line
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer accepts rx_data when rx_valid && rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, byte completed while previous one unconsumed
//   parity_err : one-cycle pulse, parity mismatch (0 without parity support)
// Modports: master = receiver, slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_timer.sv
// -----------------------------------------------------------------------------
// uart_baud_timer
// Loadable down-counter producing bit-period strobes.
//   clk, rst   : clock, synchronous active-high reset (counter -> 0)
//   en_i       : count enable
//   load_i     : load load_val_i this cycle (takes priority, no strobe)
//   load_val_i : value loaded on load_i
//   strobe_o   : high in the cycle the enabled counter sits at 0; the counter
//                reloads RELOAD on that same edge so strobes repeat every
//                RELOAD+1 clocks.
// -----------------------------------------------------------------------------
module uart_baud_timer #(
    parameter int W      = 9,
    parameter int RELOAD = 499
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         strobe_o
);

    logic [W-1:0] cnt_q;

    assign strobe_o = en_i && !load_i && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            if (cnt_q == '0) cnt_q <= W'(RELOAD);
            else             cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Frame-level UART receiver: synchronises the serial line, detects the start
// bit, samples each bit mid-period, checks the stop bit and hands bytes to
// the consumer over a valid/ready interface.
//   clk   : system clock (posedge)
//   rst   : synchronous active-high reset; aborts any frame in progress
//   data  : asynchronous serial line, idle high
//   busy  : FSM not in IDLE
//   rx_if : byte hand-off and error pulses (master modport)
// Optional build macro UART_RX_PARITY_EN adds parameter PARITY_ODD and a
// parity bit between the last data bit and the stop bit.
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int F_CLK       = 50_000_000,
    parameter int BAUDRATE    = 100_000,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data,
    output logic                 busy,
    uart_rx_frame_ctrl_if.master rx_if
);

    localparam int CPB  = clks_per_bit(F_CLK, BAUDRATE);
    localparam int HALF = half_bit(CPB);
    localparam int CW   = cnt_width(CPB);
    localparam int IW   = $clog2(DATA_BITS);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx_frame_ctrl: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_frame_ctrl: DATA_BITS must be 5..9");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx_frame_ctrl: SYNC_STAGES must be >= 2");
    end

    // ---------------- input synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], data};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // ---------------- baud timer ----------------
    rx_state_e state_q, state_d;
    logic      strobe;
    logic      tmr_load;
    logic      tmr_en;

    // The falling edge seen in IDLE is t0; loading HALF-1 puts the first
    // strobe in the middle of the start bit.
    assign tmr_load = (state_q == IDLE) && !rxs;
    assign tmr_en   = (state_q != IDLE) && (state_q != WAIT_HIGH);

    uart_baud_timer #(
        .W      (CW),
        .RELOAD (CPB - 1)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .en_i       (tmr_en),
        .load_i     (tmr_load),
        .load_val_i (CW'(HALF - 1)),
        .strobe_o   (strobe)
    );

    // ---------------- frame FSM ----------------
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver;
    logic                 ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                if (strobe) begin
                    if (rxs) begin
                        state_d = IDLE;            // glitch, not a start bit
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    // LSB arrives first, so shifting right leaves it at bit 0.
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (strobe) begin
                    par_bad_d = rxs ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (strobe) begin
`ifdef UART_RX_PARITY_EN
                    perr_d = par_bad_q;
`endif
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        deliver = !par_bad_q;
`else
                        deliver = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        // Line still low: wait for it to return high so a
                        // break is not mistaken for another start bit.
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // ---------------- consumer hand-off ----------------
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 ferr_q;
    logic                 ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= 1'b0;
            if (rx_valid_q && rx_if.rx_ready) rx_valid_q <= 1'b0;
            if (deliver) begin
                // A byte consumed on this same edge frees the slot.
                if (rx_valid_q && !rx_if.rx_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.overrun   = ovr_q;

`ifdef UART_RX_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    localparam int F_CLK = 10_000_000;
    localparam int BAUD  = 100_000;
    localparam int CPB   = F_CLK / BAUD;   // 100 clocks per bit
    localparam int HALF  = CPB / 2;
    localparam int DB    = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    // bit periods between the middle of the start bit and the middle of stop
    localparam int NSLOTS    = DB + 1 + (HAS_PAR ? 1 : 0);
    localparam int BUSY_CLKS = HALF + NSLOTS * CPB;
    // edge (counted from the edge before the line falls) on which the stop
    // sample is taken: 2 synchroniser clocks + 1 for the IDLE->START edge
    localparam int STOP_EDGE = 3 + BUSY_CLKS;

    logic clk = 1'b0;
    logic rst;
    logic data;
    logic busy;

    uart_rx_frame_ctrl_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_frame_ctrl #(
        .F_CLK       (F_CLK),
        .BAUDRATE    (BAUD),
        .DATA_BITS   (DB),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .busy  (busy),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    int obs_ferr = 0, obs_ovr = 0, obs_perr = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what a frame should produce, from the line-level
    // rules. blocked = an earlier byte will still be unconsumed on delivery.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_ok,
                               input logic blocked);
        if (!stop) exp_ferr++;
        if (!par_ok) exp_perr++;
        if (stop && par_ok) begin
            if (blocked) exp_ovr++;
            else         exp_q.push_back(b);
        end
    endtask

    task automatic check_counts(input string name);
        chk(obs_ferr == exp_ferr, {name, "_frame_err_cnt"}, obs_ferr, exp_ferr);
        chk(obs_ovr == exp_ovr, {name, "_overrun_cnt"}, obs_ovr, exp_ovr);
        chk(obs_perr == exp_perr, {name, "_parity_err_cnt"}, obs_perr, exp_perr);
    endtask

    // ---------------- line driver ----------------
    task automatic drive_bit(input logic v);
        data = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // abort_after = number of data bits sent before giving up (-1: full frame)
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                              input int abort_after);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            if (abort_after == i) begin
                data = 1'b1;
                return;
            end
            drive_bit(b[i]);
        end
        if (HAS_PAR) drive_bit((^b) ^ par_flip);
        drive_bit(stop);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       prev_hold, prev_fe, prev_ov, prev_pe;
    logic [7:0] prev_data;
    logic [7:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_fe   = 1'b0;
            prev_ov   = 1'b0;
            prev_pe   = 1'b0;
        end else begin
            if (prev_hold)
                chk(rx_if.rx_valid && rx_if.rx_data == prev_data, "hold_stable",
                    int'(rx_if.rx_data), int'(prev_data));
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                chk(exp_q.size() != 0, "unexpected_byte", int'(rx_if.rx_data), 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(rx_if.rx_data == e, "rx_data", int'(rx_if.rx_data), int'(e));
                end
            end
            if (rx_if.frame_err) begin
                obs_ferr++;
                chk(!prev_fe, "frame_err_width", 2, 1);
            end
            if (rx_if.overrun) begin
                obs_ovr++;
                chk(!prev_ov, "overrun_width", 2, 1);
            end
            if (rx_if.parity_err) begin
                obs_perr++;
                chk(!prev_pe, "parity_err_width", 2, 1);
            end
            prev_hold = rx_if.rx_valid && !rx_if.rx_ready;
            prev_data = rx_if.rx_data;
            prev_fe   = rx_if.frame_err;
            prev_ov   = rx_if.overrun;
            prev_pe   = rx_if.parity_err;
        end
    end

    initial begin
        repeat (200_000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int         bcnt;
    logic [7:0] rb;
    logic       rstop, rpf;

    initial begin
        rst = 1'b1;
        data = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(rx_if.rx_valid == 1'b0, "reset_rx_valid", int'(rx_if.rx_valid), 0);
        chk(rx_if.rx_data == 8'h00, "reset_rx_data", int'(rx_if.rx_data), 0);
        chk({rx_if.frame_err, rx_if.overrun, rx_if.parity_err} == 3'b000, "reset_flags",
            int'({rx_if.frame_err, rx_if.overrun, rx_if.parity_err}), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_if.rx_ready = 1'b1;
        repeat (5) @(posedge clk);

        // 0xA5 with busy window measurement
        model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        bcnt = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, -1);
            begin
                @(posedge clk);
                repeat (NSLOTS * CPB + 2 * CPB) begin
                    @(negedge clk);
                    if (busy) bcnt++;
                end
            end
        join
        chk(bcnt >= BUSY_CLKS - 2 && bcnt <= BUSY_CLKS + 2, "busy_len", bcnt, BUSY_CLKS);
        chk(exp_q.size() == 0, "a5_delivered", exp_q.size(), 0);
        check_counts("a5");

        // short low glitch on the idle line
        @(posedge clk);
        #1;
        data = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        data = 1'b1;
        @(negedge clk);
        chk(busy == 1'b1, "glitch_seen", int'(busy), 1);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        chk(busy == 1'b0, "glitch_rejected", int'(busy), 0);
        check_counts("glitch");

        // stop bit low, then line held low (break)
        model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        chk(busy == 1'b1, "break_wait_high", int'(busy), 1);
        check_counts("ferr");
        @(posedge clk);
        #1;
        data = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk(busy == 1'b0, "break_released", int'(busy), 0);
        model_frame(8'h81, 1'b1, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        repeat (20) @(posedge clk);
        chk(exp_q.size() == 0, "after_break_delivered", exp_q.size(), 0);
        check_counts("after_break");

        // overrun: consumer stalled over two back-to-back frames
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b0;
        model_frame(8'h11, 1'b1, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        model_frame(8'h22, 1'b1, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk(rx_if.rx_valid && rx_if.rx_data == 8'h11, "overrun_kept_old",
            int'(rx_if.rx_data), 8'h11);
        check_counts("overrun");
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk(exp_q.size() == 0, "overrun_drained", exp_q.size(), 0);

        // consumer accepts on the very edge the next byte is delivered
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b0;
        model_frame(8'h66, 1'b1, 1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b0, -1);
        repeat (5) @(posedge clk);
        model_frame(8'h77, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(8'h77, 1'b1, 1'b0, -1);
            begin
                @(posedge clk);
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                rx_if.rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_if.rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk(rx_if.rx_valid && rx_if.rx_data == 8'h77, "same_cycle_load",
            int'(rx_if.rx_data), 8'h77);
        chk(exp_q.size() == 1, "same_cycle_old_consumed", exp_q.size(), 1);
        check_counts("same_cycle");
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk(exp_q.size() == 0, "same_cycle_drained", exp_q.size(), 0);

        // reset in the middle of a frame (after data bit 3)
        send_frame(8'hFF, 1'b1, 1'b0, 4);
        chk(busy == 1'b1, "busy_before_reset", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(busy == 1'b0 && rx_if.rx_valid == 1'b0, "midframe_reset_idle",
            int'({busy, rx_if.rx_valid}), 0);
        chk(rx_if.rx_data == 8'h00, "midframe_reset_data", int'(rx_if.rx_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        repeat (20) @(posedge clk);
        chk(exp_q.size() == 0, "post_reset_delivered", exp_q.size(), 0);
        check_counts("post_reset");

`ifdef UART_RX_PARITY_EN
        // even parity: 0x5A has four ones, so a parity bit of 1 is wrong
        model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        repeat (20) @(posedge clk);
        chk(exp_q.size() == 0, "parity_bad_dropped", exp_q.size(), 0);
        check_counts("parity");
`endif

        // randomized frames: random data, occasional bad stop / parity
        for (int n = 0; n < 16; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 4) != 0);
            rpf   = HAS_PAR && ($urandom_range(0, 3) == 0);
            model_frame(rb, rstop, !rpf, 1'b0);
            send_frame(rb, rstop, rpf, -1);
            if (!rstop) begin
                repeat ($urandom_range(0, 150)) @(posedge clk);
                #1;
                data = 1'b1;
            end
            repeat ($urandom_range(2, 30)) @(posedge clk);
        end
        repeat (50) @(posedge clk);
        check_counts("final");
        chk(exp_q.size() == 0, "final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller for the UART receive path. It samples the asynchronous serial line, detects the start bit, and schedules mid-bit sample strobes from a baud counter. It assembles LSB-first data, checks the stop bit, and hands completed bytes to the consumer over a valid/ready interface. It sits between the `data` pin and any downstream byte consumer (command parser, FIFO).

Parameters:
F_CLK, 50_000_000, system clock frequency in Hz
BAUDRATE, 100_000, line rate in bit/s; CLKS_PER_BIT = F_CLK/BAUDRATE (500), HALF_BIT = CLKS_PER_BIT/2 (250)
DATA_BITS, 8, data bits per frame (5..9)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
data  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte, bit 0 = first bit on the line
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while the previous one was unconsumed
parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without the feature)
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (synchronous, active-high):
  - Synchroniser flops = 1; FSM = IDLE; counters = 0.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, parity_err = 0, busy = 0.
  - Reset mid-frame aborts the frame; no output is produced.
- `data` passes through SYNC_STAGES flops; every reference below means the synchronised value `rxs`.
- Baud counter loads a value and decrements each clock. A sample strobe fires when it reaches 0, and it reloads CLKS_PER_BIT-1 in the same cycle.
- FSM states and transitions:
  - IDLE: rxs==0 → START; counter loads HALF_BIT-1. Call this edge t0.
  - START: at the strobe (t0+HALF_BIT), rxs==1 → false start, back to IDLE with no flags. rxs==0 → DATA, bit_idx=0.
  - DATA: at each strobe, shift rxs in at the MSB (shift right), then bit_idx++. After DATA_BITS samples → STOP (or PARITY if the feature is enabled).
  - STOP: at the strobe, the sample falls at t0+HALF_BIT+(DATA_BITS+1)*CLKS_PER_BIT.
    - rxs==1 → deliver the byte, go to IDLE.
    - rxs==0 → pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then IDLE. This prevents a break condition from re-triggering a start.
- Delivery: rx_data/rx_valid update on the cycle after the stop strobe.
  - rx_valid stays high until the handshake completes.
  - rx_data is stable while rx_valid is high.
- Boundary conditions:
  - Delivery while rx_valid && !rx_ready: old byte kept, new byte dropped, overrun pulses.
  - Delivery in the same cycle as rx_valid && rx_ready: new byte loaded, rx_valid stays 1, no overrun.
  - A new start bit may be detected in the cycle after STOP→IDLE (back-to-back frames supported).
- Elaboration: error if CLKS_PER_BIT < 4 or DATA_BITS outside 5..9.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds parameter PARITY_ODD (default 0) and a PARITY state between DATA and STOP, sampled one CLKS_PER_BIT after the last data bit.
  - Expected bit = XOR(data) ^ PARITY_ODD.
  - On mismatch: parity_err pulses the cycle after the STOP strobe and the byte is discarded (rx_valid unchanged). STOP checking still applies.
  - The stop sample moves to t0+HALF_BIT+(DATA_BITS+2)*CLKS_PER_BIT.
- Undefined: no PARITY state, parity_err tied 0.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Functions clks_per_bit(F_CLK, BAUDRATE) and half_bit().
  - Counter width derived via $clog2(CLKS_PER_BIT).
- Sub-module uart_baud_timer: loadable down-counter with a strobe output (inputs load, load_val; output strobe). It is reusable by a future transmitter.

Test Plan:
- Frame 0xA5 at 100 kbaud (LSB first, stop=1), rx_ready=1 → one rx_valid pulse with rx_data=0xA5; busy high for ≈9.5 bit periods; no error flags.
- 1.5 µs (75 clk) low glitch on idle line → FSM returns to IDLE at the START strobe; no rx_valid, no flags.
- Frame 0x3C with stop bit driven 0, then line held low 3 bit times → frame_err single pulse; no rx_valid; next start not detected until line high; following 0x81 received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 held, rx_valid=1, overrun pulses once at second delivery; then rx_ready=1 accepts 0x11.
- rx_ready asserted on exactly the delivery cycle of 0x77 while 0x66 pending → 0x66 consumed, rx_data=0x77, rx_valid stays 1, overrun=0.
- rst asserted mid-frame (after bit 3 of 0xFF) → next cycle all outputs 0, FSM IDLE; subsequent 0x5A received cleanly. With UART_RX_PARITY_EN and even parity, 0x5A with parity bit 1 → parity_err pulse, no rx_valid.
